// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-back, 16 one-word lines.
// A miss stalls the pipeline through an optional writeback and a line fill.
module mem_stage_dcache (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] addr_mem,
    input  logic [31:0] wdata_mem,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic        is_word_mem,
    input  logic        is_nop_mem,
    output logic [31:0] load_data,
    output logic        lock,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_t;

    state_t      r_state;
    logic [15:0] r_valid;
    logic [15:0] r_dirty;
    logic [31:0] r_data [16];
    logic [25:0] r_tag  [16];
    logic        r_fill_done;

    logic [3:0]  w_idx;
    logic [25:0] w_tag;
    logic [4:0]  w_shamt;
    logic [31:0] w_line;
    logic        w_active;
    logic        w_idle;
    logic        w_hit;
    logic        w_acc_hit;
    logic        w_miss;
    logic [7:0]  w_byte;
    logic [31:0] w_lmask;
    logic [31:0] w_st_word;
    logic [31:0] w_ld_word;
    logic [31:0] w_fill_addr;

    assign w_idx       = addr_mem[5:2];
    assign w_tag       = addr_mem[31:6];
    assign w_shamt     = {addr_mem[1:0], 3'b000};
    assign w_line      = r_data[w_idx];
    assign w_active    = (load_mem | store_mem) & ~is_nop_mem;
    assign w_idle      = (r_state == S_IDLE);
    assign w_hit       = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_acc_hit   = w_active & w_idle & w_hit;
    assign w_miss      = w_active & w_idle & ~w_hit;
    assign w_byte      = 8'(w_line >> w_shamt);
    assign w_lmask     = 32'h0000_00FF << w_shamt;
    assign w_fill_addr = {addr_mem[31:2], 2'b00};

    // Byte stores merge into the resident word so other lanes survive
    assign w_st_word = is_word_mem ? wdata_mem
                     : (w_line & ~w_lmask) | ({24'd0, wdata_mem[7:0]} << w_shamt);
    assign w_ld_word = is_word_mem ? w_line : {{24{w_byte[7]}}, w_byte};

    assign lock      = ~rst_b & (w_miss | ~w_idle);
    assign load_data = (~rst_b & w_acc_hit & ~store_mem) ? w_ld_word : 32'd0;

    always_ff @(posedge clk) begin
        if (r_state == S_FILL && mem_ack) begin
            r_data[w_idx] <= mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_acc_hit && store_mem) begin
            r_data[w_idx] <= w_st_word;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_fill_done <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fill_done <= 1'b0;
                    if (w_acc_hit) begin
                        // the access that retires a fill was already counted as a miss
                        if (!r_fill_done)
                            hit_count <= hit_count + 16'd1;
                        if (store_mem)
                            r_dirty[w_idx] <= 1'b1;
                    end else if (w_miss) begin
                        miss_count <= miss_count + 16'd1;
                        mem_req    <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state   <= S_WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {r_tag[w_idx], w_idx, 2'b00};
                            mem_wdata <= w_line;
                        end else begin
                            r_state  <= S_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= w_fill_addr;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= S_FILL;
                        mem_we         <= 1'b0;
                        mem_addr       <= w_fill_addr;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= S_IDLE;
                        mem_req        <= 1'b0;
                        r_fill_done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Scoreboard bench for mem_stage_dcache: directed accesses, a responding
// memory model that acks three cycles into each request.
module tb_mem_stage_dcache;
    logic        clk;
    logic        rst_b;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic        load_mem;
    logic        store_mem;
    logic        is_word_mem;
    logic        is_nop_mem;
    logic [31:0] load_data;
    logic        lock;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    logic [31:0] exp_load [$];
    mexp_t       exp_mem  [$];
    logic [31:0] mem_model [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b1;

    mem_stage_dcache dut (
        .clk(clk), .rst_b(rst_b),
        .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .load_mem(load_mem), .store_mem(store_mem),
        .is_word_mem(is_word_mem), .is_nop_mem(is_nop_mem),
        .load_data(load_data), .lock(lock),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
        mexp_t e;
        e.we = we;
        e.addr = a;
        e.wdata = wd;
        exp_mem.push_back(e);
    endtask

    task automatic access(input logic ld, input logic st, input logic word,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_ld, input int exp_lk,
                          input string name);
        int lk;
        @(posedge clk); #1;
        load_mem = ld;
        store_mem = st;
        is_word_mem = word;
        is_nop_mem = 1'b0;
        addr_mem = a;
        wdata_mem = wd;
        if (ld && !st) exp_load.push_back(exp_ld);
        lk = 0;
        @(negedge clk);
        while (lock && lk < 50) begin
            lk++;
            @(negedge clk);
        end
        chk({name, "_lock_cycles"}, 32'(lk), 32'(exp_lk));
        @(posedge clk); #1;
        load_mem = 1'b0;
        store_mem = 1'b0;
    endtask

    // load-result monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst_b && !lock && load_mem && !store_mem && !is_nop_mem) begin
                if (exp_load.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL load_unexpected: got %h expected none", load_data);
                end else begin
                    chk("load_data", load_data, exp_load.pop_front());
                end
            end
        end
    end

    // memory responder and memory-side monitor
    initial begin
        int cnt;
        mexp_t e;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    if (exp_mem.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: got addr %h expected none", mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_we)
                        mem_model[mem_addr] = mem_wdata;
                    else
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'd0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        mem_model[32'h40]  = 32'h1122_3344;
        mem_model[32'h400] = 32'hCAFE_F00D;
        mem_model[32'h84]  = 32'h99AA_BBCC;
        rst_b = 1'b1;
        load_mem = 1'b1;
        store_mem = 1'b0;
        is_word_mem = 1'b1;
        is_nop_mem = 1'b0;
        addr_mem = 32'h40;
        wdata_mem = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_misses", 32'(miss_count), 32'd0);
        @(posedge clk); #2;
        rst_b = 1'b0;
        load_mem = 1'b0;

        // cold word load
        push_mem(1'b0, 32'h40, 32'd0);
        access(1, 0, 1, 32'h40, 0, 32'h1122_3344, 4, "cold_load");
        chk("cold_misses", 32'(miss_count), 32'd1);
        chk("cold_hits", 32'(hit_count), 32'd0);

        // byte store then byte and word reloads
        access(0, 1, 0, 32'h41, 32'h0000_00AB, 0, 0, "bst_41");
        access(1, 0, 0, 32'h41, 0, 32'hFFFF_FFAB, 0, "bld_41");
        access(1, 0, 1, 32'h40, 0, 32'h1122_AB44, 0, "wld_40");
        chk("hits_3", 32'(hit_count), 32'd3);

        // dirty victim 0x40 evicted by 0x400
        push_mem(1'b1, 32'h40, 32'h1122_AB44);
        push_mem(1'b0, 32'h400, 32'd0);
        access(1, 0, 1, 32'h400, 0, 32'hCAFE_F00D, 7, "evict_40");
        chk("misses_2", 32'(miss_count), 32'd2);

        // store-miss to 0x0, then evict it with 0x400
        push_mem(1'b0, 32'h0, 32'd0);
        access(0, 1, 1, 32'h0, 32'hDEAD_BEEF, 0, 4, "st_miss_0");
        push_mem(1'b1, 32'h0, 32'hDEAD_BEEF);
        push_mem(1'b0, 32'h400, 32'd0);
        access(1, 0, 1, 32'h400, 0, 32'hCAFE_F00D, 7, "evict_0");
        chk("hits_after_evict", 32'(hit_count), 32'd3);
        chk("misses_4", 32'(miss_count), 32'd4);

        // bubble with load asserted
        @(posedge clk); #1;
        load_mem = 1'b1;
        is_nop_mem = 1'b1;
        addr_mem = 32'h80;
        @(negedge clk);
        chk("nop_lock", 32'(lock), 32'd0);
        chk("nop_mem_req", 32'(mem_req), 32'd0);
        chk("nop_load_data", load_data, 32'd0);
        @(posedge clk); #1;
        load_mem = 1'b0;
        is_nop_mem = 1'b0;
        chk("nop_hits", 32'(hit_count), 32'd3);
        chk("nop_misses", 32'(miss_count), 32'd4);
        chk("nop_mem_req_after", 32'(mem_req), 32'd0);

        // lanes, sign extension, load+store as store
        access(1, 0, 0, 32'h403, 0, 32'hFFFF_FFCA, 0, "bld_403");
        access(1, 0, 0, 32'h400, 0, 32'h0000_000D, 0, "bld_400");
        access(0, 1, 0, 32'h402, 32'h0000_007E, 0, 0, "bst_402");
        access(1, 0, 1, 32'h400, 0, 32'hCA7E_F00D, 0, "wld_400");
        access(1, 0, 1, 32'h401, 0, 32'hCA7E_F00D, 0, "wld_401");
        access(1, 1, 1, 32'h400, 32'h1234_5678, 0, 0, "ldst_400");
        access(1, 0, 1, 32'h400, 0, 32'h1234_5678, 0, "wld_after_ldst");
        chk("hits_10", 32'(hit_count), 32'd10);
        chk("misses_still_4", 32'(miss_count), 32'd4);

        // reset during a fill
        @(posedge clk); #1;
        load_mem = 1'b1;
        is_word_mem = 1'b1;
        addr_mem = 32'h84;
        @(negedge clk);
        chk("abort_miss_lock", 32'(lock), 32'd1);
        @(negedge clk);
        chk("abort_fill_req", 32'(mem_req), 32'd1);
        chk("abort_fill_addr", mem_addr, 32'h84);
        #2 rst_b = 1'b1;
        #1;
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        chk("abort_lock", 32'(lock), 32'd0);
        chk("abort_load_data", load_data, 32'd0);
        @(posedge clk); #2;
        rst_b = 1'b0;
        load_mem = 1'b0;
        chk("abort_hits", 32'(hit_count), 32'd0);
        chk("abort_misses", 32'(miss_count), 32'd0);

        push_mem(1'b0, 32'h84, 32'd0);
        access(1, 0, 1, 32'h84, 0, 32'h99AA_BBCC, 4, "remiss_84");
        chk("remiss_misses", 32'(miss_count), 32'd1);
        push_mem(1'b0, 32'h400, 32'd0);
        access(1, 0, 1, 32'h400, 0, 32'hCAFE_F00D, 4, "remiss_400");
        chk("remiss_misses_2", 32'(miss_count), 32'd2);

        // hit counter wrap
        @(posedge clk); #1;
        mon_en = 1'b0;
        load_mem = 1'b1;
        is_word_mem = 1'b1;
        addr_mem = 32'h400;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_hits_ffff", 32'(hit_count), 32'h0000_FFFF);
        chk("wrap_load_data", load_data, 32'hCAFE_F00D);
        chk("wrap_lock", 32'(lock), 32'd0);
        @(posedge clk); #1;
        chk("wrap_hits_0", 32'(hit_count), 32'd0);
        chk("wrap_misses", 32'(miss_count), 32'd2);
        load_mem = 1'b0;
        mon_en = 1'b1;

        repeat (2) @(posedge clk);
        chk("load_queue_empty", 32'(exp_load.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
